tie_inq_source: RTL and testbench

Verilog-side producer for a processor TIE input queue in the XTSC cosim.
- Accepts words from a bench-side source through a valid/ready handshake and buffers them in a small FIFO.
- Presents the head word to the core on the TIE input-queue interface (data / Empty / PopReq).
- Counterpart to the loop-back path that carries processor-exported state out to Verilog; this block carries data into the core with queue semantics and back-pressure.

---
 rtl/tie_inq_source.sv | 111 +++++++++++
 tb/tb_tie_inq_source.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/tie_inq_source.sv
// TIE input-queue source: buffers bench-side words in a small FIFO and presents the head
// word to the core. Optional macro TIE_INQ_DISPLAY_EN enables push/pop/underrun tracing.
module tie_inq_source #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned STALL_W    = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [DATA_W-1:0]     SRC_DATA,
    input  logic                  SRC_VALID,
    output logic                  SRC_READY,
    output logic [DATA_W-1:0]     TIE_INQ,
    output logic                  TIE_INQ_Empty,
    input  logic                  TIE_INQ_PopReq,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic [STALL_W-1:0]    STALL_CNT
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned PtrW  = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam int unsigned CntW  = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]  mem_q [0:Depth-1];
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic full, empty, push, pop, stall;

    // Wrap at Depth-1; with a single entry the pointer stays at zero.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Full/empty come from registered occupancy only, never from pointer equality.
    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    assign push  = SRC_VALID & ~full;
    assign pop   = TIE_INQ_PopReq & ~empty;
    assign stall = TIE_INQ_PopReq & empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
        if (stall && !(&stall_q)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Storage is never cleared; a word offered during reset is dropped.
    always_ff @(posedge CLK) begin
        if (push && !Reset) begin
            mem_q[wr_ptr_q] <= SRC_DATA;
        end
    end

    assign SRC_READY     = ~full;
    assign TIE_INQ_Empty = empty;
    assign TIE_INQ       = empty ? '0 : mem_q[rd_ptr_q];
    assign COUNT         = count_q;
    assign STALL_CNT     = stall_q;

`ifdef TIE_INQ_DISPLAY_EN
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            if (push) begin
                $display("%t INQ push 0x%h count=%0d", $time, SRC_DATA, count_d);
            end
            if (pop) begin
                $display("%t INQ pop 0x%h count=%0d", $time, TIE_INQ, count_d);
            end
        end
        if (!empty && (Reset || count_d == '0)) begin
            $display("%t INQ underrun-ready", $time);
        end
    end
`endif

endmodule

// File: tb/tb_tie_inq_source.sv
// Self-checking bench for tie_inq_source: directed plan steps then random traffic,
// all compared against a queue-based occupancy/stall model.
module tb_tie_inq_source;

    localparam int unsigned DataW = 32;
    localparam int unsigned Depth = 4;

    logic             clk;
    logic             rst;
    logic [DataW-1:0] src_data;
    logic             src_valid;
    logic             src_ready, src_ready4;
    logic [DataW-1:0] inq, inq4;
    logic             empty, empty4;
    logic             pop_req;
    logic [2:0]       count, count4;
    logic [15:0]      stall_cnt;
    logic [3:0]       stall_cnt4;

    tie_inq_source #(.DATA_W(32), .DEPTH_LOG2(2), .STALL_W(16)) dut (
        .CLK            (clk),
        .Reset          (rst),
        .SRC_DATA       (src_data),
        .SRC_VALID      (src_valid),
        .SRC_READY      (src_ready),
        .TIE_INQ        (inq),
        .TIE_INQ_Empty  (empty),
        .TIE_INQ_PopReq (pop_req),
        .COUNT          (count),
        .STALL_CNT      (stall_cnt)
    );

    // Narrow stall counter instance to exercise saturation.
    tie_inq_source #(.DATA_W(32), .DEPTH_LOG2(2), .STALL_W(4)) dut_s4 (
        .CLK            (clk),
        .Reset          (rst),
        .SRC_DATA       (src_data),
        .SRC_VALID      (src_valid),
        .SRC_READY      (src_ready4),
        .TIE_INQ        (inq4),
        .TIE_INQ_Empty  (empty4),
        .TIE_INQ_PopReq (pop_req),
        .COUNT          (count4),
        .STALL_CNT      (stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [DataW-1:0] q[$];
    int stall_m  = 0;
    int stall4_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Apply one cycle of stimulus, compare outputs to the model, then advance both.
    task automatic step(input logic r, input logic v, input logic [DataW-1:0] d,
                        input logic p);
        logic m_empty, m_full;
        logic [DataW-1:0] m_head;
        rst       = r;
        src_valid = v;
        src_data  = d;
        pop_req   = p;
        #1;
        m_empty = (q.size() == 0);
        m_full  = (q.size() == Depth);
        m_head  = m_empty ? '0 : q[0];
        check("count", 64'(count), 64'(q.size()));
        check("ready", 64'(src_ready), 64'(!m_full));
        check("empty", 64'(empty), 64'(m_empty));
        check("inq", 64'(inq), 64'(m_head));
        check("stall", 64'(stall_cnt), 64'(stall_m));
        check("stall4", 64'(stall_cnt4), 64'(stall4_m));
        check("inq_w4", 64'(inq4), 64'(m_head));
        if (r) begin
            q.delete();
            stall_m  = 0;
            stall4_m = 0;
        end else begin
            if (p && m_empty) begin
                stall_m  = (stall_m  < 65535) ? stall_m + 1  : 65535;
                stall4_m = (stall4_m < 15)    ? stall4_m + 1 : 15;
            end
            if (p && !m_empty) void'(q.pop_front());
            if (v && !m_full) q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        src_valid = 1'b0;
        src_data  = '0;
        pop_req   = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset then idle.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // Fill, refused fifth push, drain.
        step(0, 1, 32'h11, 0);
        step(0, 1, 32'h22, 0);
        step(0, 1, 32'h33, 0);
        step(0, 1, 32'h44, 0);
        step(0, 1, 32'h55, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'hDEAD, 1);
        step(0, 0, 0, 0);

        // Steady state at occupancy 2 with simultaneous push/pop across wrap.
        step(0, 1, 32'h01, 0);
        step(0, 1, 32'h02, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 32'hA0 + 32'(i), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Stall while empty, then push and pop the word.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 1, 32'hBEEF, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Reset overrides push and pop.
        step(0, 1, 32'h100, 0);
        step(0, 1, 32'h101, 0);
        step(0, 1, 32'h102, 0);
        step(1, 1, 32'h103, 1);
        step(0, 0, 0, 0);

        // Saturation of the narrow stall counter.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Random traffic with rare resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), $urandom,
                 ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
